int_iq_age_tracker: RTL and testbench

INT_IQ_AGE_TRACKER -- requirements
Module: int_iq_age_tracker

---
 rtl/Falco_pkg.sv | 8 +
 rtl/int_iq_age_tracker_if.sv | 23 ++
 rtl/int_iq_free_finder2.sv | 28 ++
 rtl/int_iq_age_tracker.sv | 95 +++++++++
 tb/tb_int_iq_age_tracker.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/Falco_pkg.sv
// Shared issue-queue sizing and the id and age types used by the integer IQ blocks.
package Falco_pkg;
  localparam int INT_IQ_WIDTH = 3;
  localparam int IQ_DEPTH     = 1 << INT_IQ_WIDTH;

  typedef logic [INT_IQ_WIDTH-1:0] iq_id_t;
  typedef logic [INT_IQ_WIDTH:0]   iq_age_t;
endpackage

// File: rtl/int_iq_age_tracker_if.sv
// Dispatch, issue and picker-facing signals of the integer IQ age tracker.
interface int_iq_age_tracker_if;
  import Falco_pkg::*;

  logic [1:0]               disp_valid;
  logic                     disp_ready;
  iq_id_t [1:0]             alloc_id;
  logic [1:0]               issue_valid;
  iq_id_t [1:0]             issue_id;
  logic [IQ_DEPTH-1:0]      entry_valid;
  iq_age_t [IQ_DEPTH-1:0]   entry_age;
  iq_age_t                  free_cnt;

  modport master (
    output disp_valid, issue_valid, issue_id,
    input  disp_ready, alloc_id, entry_valid, entry_age, free_cnt
  );

  modport slave (
    input  disp_valid, issue_valid, issue_id,
    output disp_ready, alloc_id, entry_valid, entry_age, free_cnt
  );
endinterface

// File: rtl/int_iq_free_finder2.sv
// Lowest two free (zero) positions of the valid vector; combinational, no backpressure.
module int_iq_free_finder2
  import Falco_pkg::*;
(
  input  logic [IQ_DEPTH-1:0] valid,
  output iq_id_t [1:0]        free_id
);

  logic [1:0] nfound;

  always_comb begin
    free_id = '0;
    nfound  = 2'd0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!valid[i]) begin
        if (nfound == 2'd0) begin
          free_id[0] = iq_id_t'(i);
        end else if (nfound == 2'd1) begin
          free_id[1] = iq_id_t'(i);
        end
        if (nfound != 2'd2) begin
          nfound = nfound + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/int_iq_age_tracker.sv
// Age matrix for the integer IQ: entry age = number of younger valid entries.
// One-cycle update latency; dispatch is held off (disp_ready low) when fewer than two entries are free.
module int_iq_age_tracker
  import Falco_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  int_iq_age_tracker_if.slave  iq
);

  logic [IQ_DEPTH-1:0]    valid_q, valid_d, iss_vec;
  iq_age_t [IQ_DEPTH-1:0] age_q, age_d;
  iq_age_t                free_q, free_d, k, n_iss;
  iq_id_t [1:0]           free_id;
  iq_id_t                 slot1;
  logic                   ready, acc0, acc1;

  int_iq_free_finder2 u_free_finder (
    .valid   (valid_q),
    .free_id (free_id)
  );

  assign ready          = (free_q >= iq_age_t'(2));
  assign iq.disp_ready  = ready;
  assign iq.alloc_id    = free_id;
  assign iq.entry_valid = valid_q;
  assign iq.entry_age   = age_q;
  assign iq.free_cnt    = free_q;

  always_comb begin
    acc0    = iq.disp_valid[0] && ready && !flush;
    acc1    = iq.disp_valid[1] && ready && !flush;
    k       = iq_age_t'(acc0) + iq_age_t'(acc1);
    slot1   = acc0 ? free_id[1] : free_id[0];
    iss_vec = '0;
    n_iss   = '0;
    age_d   = '0;

    // Duplicate grants land on the same bit, so they count once.
    for (int n = 0; n < 2; n++) begin
      if (iq.issue_valid[n] && valid_q[iq.issue_id[n]]) begin
        iss_vec[iq.issue_id[n]] = 1'b1;
      end
    end
    for (int j = 0; j < IQ_DEPTH; j++) begin
      n_iss = n_iss + iq_age_t'(iss_vec[j]);
    end

    valid_d = valid_q & ~iss_vec;
    for (int i = 0; i < IQ_DEPTH; i++) begin : g_age
      iq_age_t fi;
      fi = '0;
      if (valid_d[i]) begin
        for (int j = 0; j < IQ_DEPTH; j++) begin
          if (iss_vec[j] && (age_q[j] < age_q[i])) begin
            fi = fi + iq_age_t'(1);
          end
        end
        age_d[i] = age_q[i] + k - fi;
      end
    end

    // New entries are younger than every survivor; slot 0 is the older of a pair.
    if (acc0) begin
      valid_d[free_id[0]] = 1'b1;
      age_d[free_id[0]]   = acc1 ? iq_age_t'(1) : iq_age_t'(0);
    end
    if (acc1) begin
      valid_d[slot1] = 1'b1;
      age_d[slot1]   = '0;
    end

    free_d = free_q + n_iss - k;

    if (flush) begin
      valid_d = '0;
      age_d   = '0;
      free_d  = iq_age_t'(IQ_DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      age_q   <= '0;
      free_q  <= iq_age_t'(IQ_DEPTH);
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      free_q  <= free_d;
    end
  end

endmodule

// File: tb/tb_int_iq_age_tracker.sv
// Scoreboard bench: an oldest-first list model predicts occupancy, ages and free count each cycle.
module tb_int_iq_age_tracker;
  import Falco_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  int_iq_age_tracker_if iqi ();

  int_iq_age_tracker dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .iq    (iqi.slave)
  );

  typedef struct packed {
    logic [7:0]  v;
    logic [31:0] age;
    logic [3:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  int   ord[$];          // valid entry ids, oldest first
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   known   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    e.v   = '0;
    e.age = '0;
    e.fc  = 4'(8 - ord.size());
    for (int p = 0; p < ord.size(); p++) begin
      e.v[ord[p]]          = 1'b1;
      e.age[ord[p]*4 +: 4] = 4'(ord.size() - 1 - p);
    end
    return e;
  endfunction

  task automatic remove_id(input int id);
    for (int p = 0; p < ord.size(); p++) begin
      if (ord[p] == id) begin
        ord.delete(p);
        break;
      end
    end
  endtask

  task automatic cycle(input bit rs, input bit fl, input bit [1:0] dv,
                       input bit [1:0] iv, input int i0, input int i1);
    logic [7:0] mv;
    int   free;
    bit   rdy;
    int   a0, a1, na;
    exp_t e;
    mv = '0;
    foreach (ord[p]) mv[ord[p]] = 1'b1;
    free = 8 - ord.size();
    rdy  = (free >= 2);
    a0 = 0; a1 = 0; na = 0;
    for (int i = 0; i < 8; i++) begin
      if (!mv[i]) begin
        if (na == 0) a0 = i;
        else if (na == 1) a1 = i;
        na++;
      end
    end
    if (known) begin
      chk("disp_ready", 64'(iqi.disp_ready), 64'(rdy));
      if (rdy) begin
        chk("alloc_id0", 64'(iqi.alloc_id[0]), 64'(a0));
        chk("alloc_id1", 64'(iqi.alloc_id[1]), 64'(a1));
      end
    end

    rst = rs;
    flush = fl;
    iqi.disp_valid  = dv;
    iqi.issue_valid = iv;
    iqi.issue_id[0] = 3'(i0);
    iqi.issue_id[1] = 3'(i1);

    if (rs || fl) begin
      ord.delete();
    end else begin
      if (iv[0]) remove_id(i0);
      if (iv[1]) remove_id(i1);
      if (rdy) begin
        if (dv[0]) ord.push_back(a0);
        if (dv[1]) ord.push_back(dv[0] ? a1 : a0);
      end
    end
    exp_q.push_back(model_snap());

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("entry_valid", 64'(iqi.entry_valid), 64'(e.v));
    chk("entry_age",   64'(iqi.entry_age),   64'(e.age));
    chk("free_cnt",    64'(iqi.free_cnt),    64'(e.fc));

    rst = 1'b0;
    flush = 1'b0;
    iqi.disp_valid  = '0;
    iqi.issue_valid = '0;
    iqi.issue_id    = '0;
    if (rs) known = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    iqi.disp_valid  = '0;
    iqi.issue_valid = '0;
    iqi.issue_id    = '0;

    cycle(1, 0, 2'b00, 2'b00, 0, 0);
    cycle(1, 0, 2'b00, 2'b00, 0, 0);

    // Single dual dispatch from empty
    cycle(0, 0, 2'b11, 2'b00, 0, 0);
    chk("r21_age0", 64'(iqi.entry_age[0]), 64'd1);
    chk("r21_age1", 64'(iqi.entry_age[1]), 64'd0);
    chk("r21_free", 64'(iqi.free_cnt), 64'd6);

    // Fill, then a dispatch that must be ignored
    repeat (3) cycle(0, 0, 2'b11, 2'b00, 0, 0);
    chk("r22_free", 64'(iqi.free_cnt), 64'd0);
    chk("r22_ready", 64'(iqi.disp_ready), 64'd0);
    for (int i = 0; i < 8; i++) chk("r22_age", 64'(iqi.entry_age[i]), 64'(7 - i));
    cycle(0, 0, 2'b11, 2'b00, 0, 0);

    // Issue the age-4 entry (idx 3) from a full queue
    cycle(0, 0, 2'b00, 2'b01, 3, 0);
    chk("r23_age0", 64'(iqi.entry_age[0]), 64'd6);
    chk("r23_age2", 64'(iqi.entry_age[2]), 64'd4);
    chk("r23_age4", 64'(iqi.entry_age[4]), 64'd3);
    chk("r23_free", 64'(iqi.free_cnt), 64'd1);
    chk("r23_ready", 64'(iqi.disp_ready), 64'd0);

    // Flush beats dispatch and issue
    cycle(0, 1, 2'b11, 2'b11, 0, 1);
    chk("r25_valid", 64'(iqi.entry_valid), 64'd0);
    chk("r25_free", 64'(iqi.free_cnt), 64'd8);

    // Simultaneous issue of idx0/idx2 with dual dispatch
    cycle(0, 0, 2'b11, 2'b00, 0, 0);
    cycle(0, 0, 2'b11, 2'b00, 0, 0);
    cycle(0, 0, 2'b11, 2'b11, 0, 2);
    chk("r24_age4", 64'(iqi.entry_age[4]), 64'd1);
    chk("r24_age5", 64'(iqi.entry_age[5]), 64'd0);
    chk("r24_age1", 64'(iqi.entry_age[1]), 64'd3);
    chk("r24_age3", 64'(iqi.entry_age[3]), 64'd2);
    chk("r24_free", 64'(iqi.free_cnt), 64'd4);

    // Reset mid-operation discards in-flight requests
    cycle(1, 0, 2'b11, 2'b11, 1, 4);
    chk("rst_valid", 64'(iqi.entry_valid), 64'd0);
    chk("rst_free", 64'(iqi.free_cnt), 64'd8);
    chk("rst_ready", 64'(iqi.disp_ready), 64'd1);
    chk("rst_alloc1", 64'(iqi.alloc_id[1]), 64'd1);

    // Duplicate grant counts once; grant to an invalid entry is ignored
    cycle(0, 0, 2'b11, 2'b00, 0, 0);
    cycle(0, 0, 2'b11, 2'b00, 0, 0);
    cycle(0, 0, 2'b00, 2'b11, 3, 3);
    chk("dup_free", 64'(iqi.free_cnt), 64'd5);
    chk("dup_valid", 64'(iqi.entry_valid), 64'h07);
    cycle(0, 0, 2'b00, 2'b01, 6, 0);
    chk("inv_free", 64'(iqi.free_cnt), 64'd5);

    // Random dispatch / issue traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      cycle(0, ($urandom_range(0, 31) == 0), 2'($urandom), 2'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
